// File: rtl/fpu_issue_arbiter_if.sv
// rtl/fpu_issue_arbiter_if.sv - request/response bundle between requesters and the FPU issue arbiter
interface fpu_issue_arbiter_if;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [13:0]  req_opcode;
  logic [5:0]   req_rm;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_id;
  logic [63:0]  resp_result;
  logic [3:0]   resp_flags;
  logic [3:0]   resp_cmp;

  modport master (
    output req_valid, req_opcode, req_rm, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_flags, resp_cmp
  );

  modport slave (
    input  req_valid, req_opcode, req_rm, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_flags, resp_cmp
  );
endinterface

// File: rtl/fpu_issue_arbiter.sv
// rtl/fpu_issue_arbiter.sv - round-robin two-requester front end for one shared FPU (option: FPU_ACCRUED_FLAGS_EN)
module fpu_issue_arbiter #(
  parameter int unsigned LAT_ADD  = 3,
  parameter int unsigned LAT_MUL  = 3,
  parameter int unsigned LAT_DIV  = 12,
  parameter int unsigned LAT_SQRT = 12,
  parameter int unsigned LAT_CVT  = 2,
  parameter int unsigned LAT_CMP  = 1,
  parameter int unsigned CNT_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  fpu_issue_arbiter_if.slave  bus,
  output logic [6:0]          fpu_opcode,
  output logic [2:0]          fpu_rm,
  output logic [63:0]         fpu_a,
  output logic [63:0]         fpu_b,
  input  logic [63:0]         fpu_result,
  input  logic [3:0]          fpu_flags,
  input  logic [3:0]          fpu_cmp,
  output logic                busy
`ifdef FPU_ACCRUED_FLAGS_EN
  ,
  input  logic                flags_clr,
  output logic [3:0]          accrued_flags
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           state_q, state_d;
  logic             rr_q;
  logic             g_q;
  logic [CNT_W-1:0] cnt_q;
  logic             gnt;
  logic             gnt_valid;
  logic [1:0]       req_ready_c;
  logic [6:0]       sel_opcode;
  logic [2:0]       sel_rm;
  logic [63:0]      sel_a;
  logic [63:0]      sel_b;

  // Counter preload is latency minus one; unknown opcodes resolve in a single cycle.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [6:0] op);
    int unsigned lat;
    case (op[6:2])
      5'b00000, 5'b00001: lat = LAT_ADD;
      5'b00010:           lat = LAT_MUL;
      5'b00011:           lat = LAT_DIV;
      5'b01011:           lat = LAT_SQRT;
      5'b10100:           lat = LAT_CMP;
      5'b00100, 5'b00101: lat = LAT_CVT;
      default:            lat = 1;
    endcase
    return CNT_W'(lat - 1);
  endfunction

  // Round-robin grant: the pointer side wins when valid, otherwise the other side.
  always_comb begin
    gnt       = rr_q;
    gnt_valid = 1'b0;
    if (bus.req_valid[rr_q]) begin
      gnt       = rr_q;
      gnt_valid = 1'b1;
    end else if (bus.req_valid[~rr_q]) begin
      gnt       = ~rr_q;
      gnt_valid = 1'b1;
    end
  end

  assign sel_opcode = gnt ? bus.req_opcode[13:7] : bus.req_opcode[6:0];
  assign sel_rm     = gnt ? bus.req_rm[5:3]      : bus.req_rm[2:0];
  assign sel_a      = gnt ? bus.req_a[127:64]    : bus.req_a[63:0];
  assign sel_b      = gnt ? bus.req_b[127:64]    : bus.req_b[63:0];

  // Next-state decode and the IDLE-only request accept.
  always_comb begin
    state_d     = state_q;
    req_ready_c = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          req_ready_c[gnt] = 1'b1;
          state_d          = S_EXEC;
        end
      end
      S_EXEC: if (cnt_q == '0) state_d = S_RESP;
      S_RESP: if (bus.resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready = req_ready_c;
  assign busy          = (state_q != S_IDLE);

  // Latch the granted op, count down its latency, capture the FPU answer, hold it until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      rr_q            <= 1'b0;
      g_q             <= 1'b0;
      cnt_q           <= '0;
      fpu_opcode      <= '0;
      fpu_rm          <= '0;
      fpu_a           <= '0;
      fpu_b           <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_id     <= 1'b0;
      bus.resp_result <= '0;
      bus.resp_flags  <= '0;
      bus.resp_cmp    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (gnt_valid) begin
            fpu_opcode <= sel_opcode;
            fpu_rm     <= sel_rm;
            fpu_a      <= sel_a;
            fpu_b      <= sel_b;
            g_q        <= gnt;
            cnt_q      <= lat_m1(sel_opcode);
          end
        end
        S_EXEC: begin
          if (cnt_q == '0) begin
            bus.resp_valid  <= 1'b1;
            bus.resp_id     <= g_q;
            bus.resp_result <= fpu_result;
            bus.resp_flags  <= fpu_flags;
            bus.resp_cmp    <= fpu_cmp;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            rr_q           <= ~g_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FPU_ACCRUED_FLAGS_EN
  // Sticky OR of delivered flags; a clear takes effect before the same-cycle response is merged.
  always_ff @(posedge clk) begin
    if (rst) begin
      accrued_flags <= '0;
    end else begin
      accrued_flags <= (flags_clr ? 4'b0000 : accrued_flags) |
                       ((state_q == S_RESP && bus.resp_ready) ? bus.resp_flags : 4'b0000);
    end
  end
`endif

endmodule
